nco_period_meter: RTL and testbench

- Measures the period and high time of a slow square wave, in system-clock cycles; typically that wave is the 1 Hz-class output of the team's numerically controlled oscillator.
- This is the measuring end of the NCO link: it recovers the divide count from the generated waveform so that dividers can be self-checked and displayed.
- It synchronises the asynchronous input, detects its edges and runs a small FSM. Each full period produces one result pulse.

---
 rtl/nco_meter_pkg.sv | 16 +
 rtl/sync_edge_det.sv | 33 +++
 rtl/nco_period_meter.sv | 143 ++++++++++++++
 tb/tb_nco_period_meter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_meter_pkg.sv
// Shared types and defaults for the NCO period meter.
// Holds the FSM state encoding and the default sizing constants.
package nco_meter_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_TIMEOUT = 100_000_000;
    localparam int CLK_HZ          = 50_000_000;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Input synchroniser plus edge detector for one asynchronous signal.
// Ports: clk, rst (sync, active-high), i_sig (async in),
//        o_rise / o_fall (one-cycle detect pulses).
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_hist <= w_sync;
        end
    end

    assign o_rise = w_sync & ~r_hist;
    assign o_fall = ~w_sync & r_hist;

endmodule

// File: rtl/nco_period_meter.sv
// Measures period and high time of a slow square wave in clk cycles.
// Ports: clk, rst (sync, active-high), en, sig_in (async);
//        period, high_time, valid (1-cycle pulse), timeout (sticky), busy.
module nco_period_meter
    import nco_meter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [WIDTH-1:0] TO_VAL = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    meter_state_t     r_state;
    meter_state_t     w_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] w_high;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] w_period;
    logic [WIDTH-1:0] r_high_time;
    logic [WIDTH-1:0] w_high_time;
    logic             r_valid;
    logic             w_valid;
    logic             r_timeout;
    logic             w_timeout;
    logic             w_rise;
    logic             w_fall;
    logic             w_at_limit;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .i_sig (sig_in),
        .o_rise(w_rise),
        .o_fall(w_fall)
    );

    assign w_at_limit = (r_cnt == TO_VAL);

    // A qualifying edge is tested before the limit, so an edge landing
    // on the limit cycle still completes the measurement.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_high      = r_high;
        w_period    = r_period;
        w_high_time = r_high_time;
        w_valid     = 1'b0;
        w_timeout   = r_timeout;
        if (!en) begin
            w_state   = IDLE;
            w_cnt     = '0;
            w_timeout = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state = ARM;
                end
                ARM: begin
                    if (w_rise) begin
                        w_cnt   = ONE;
                        w_state = HIGH;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        w_high  = r_cnt;
                        w_cnt   = r_cnt + ONE;
                        w_state = LOW;
                    end else if (w_at_limit) begin
                        w_timeout = 1'b1;
                        w_cnt     = '0;
                        w_state   = ARM;
                    end else begin
                        w_cnt = r_cnt + ONE;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_period    = r_cnt;
                        w_high_time = r_high;
                        w_valid     = 1'b1;
                        w_timeout   = 1'b0;
                        w_cnt       = ONE;
                        w_state     = HIGH;
                    end else if (w_at_limit) begin
                        w_timeout = 1'b1;
                        w_cnt     = '0;
                        w_state   = ARM;
                    end else begin
                        w_cnt = r_cnt + ONE;
                    end
                end
                default: begin
                    w_state = IDLE;
                    w_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_high      <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_high      <= w_high;
            r_period    <= w_period;
            r_high_time <= w_high_time;
            r_valid     <= w_valid;
            r_timeout   <= w_timeout;
        end
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign timeout   = r_timeout;
    assign busy      = (r_state == HIGH) || (r_state == LOW);

endmodule

// File: tb/tb_nco_period_meter.sv
// Self-checking bench for nco_period_meter (TIMEOUT shortened to 50).
// Table-driven waveforms plus hand sequences; results via scoreboard.
module tb_nco_period_meter;
    import nco_meter_pkg::*;

    localparam int W  = 32;
    localparam int TO = 50;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;
    logic         busy;

    nco_period_meter #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .TIMEOUT    (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sig_in   (sig_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int per;
        int hi;
        int gap;
    } exp_t;

    typedef struct {
        int h;
        int l;
        int n;
        int exp_p;
        int exp_h;
    } row_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   last_vcyc = -100;
    logic prev_valid = 1'b0;
    logic busy_ok;

    task automatic check(input string name, input longint act,
                         input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest pending result.
    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            check("valid_not_back_to_back", prev_valid, 0);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: valid=1 with period=%0d, required no pulse",
                         period);
            end else begin
                e = q.pop_front();
                check("period", period, e.per);
                check("high_time", high_time, e.hi);
                check("timeout_at_valid", timeout, 0);
                if (e.gap != 0)
                    check("valid_gap", cyc - last_vcyc, e.gap);
            end
            last_vcyc = cyc;
        end
        prev_valid = valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic step_chk(inout int t);
        tick(1);
        t++;
        if (t >= 4 && busy !== 1'b1) busy_ok = 1'b0;
    endtask

    // n full periods then a closing rise; each rise after the first
    // completes one period and queues its expected result.
    task automatic drive(input int h, input int l, input int n,
                         input int ep, input int eh);
        int   t;
        exp_t e;
        t = 0;
        busy_ok = 1'b1;
        for (int i = 0; i <= n; i++) begin
            sig_in = 1'b1;
            if (i > 0) begin
                e.per = ep;
                e.hi  = eh;
                e.gap = (i > 1) ? ep : 0;
                q.push_back(e);
            end
            if (i == n) break;
            for (int j = 0; j < h; j++) step_chk(t);
            sig_in = 1'b0;
            for (int j = 0; j < l; j++) step_chk(t);
        end
    endtask

    task automatic finish_run();
        tick(6);
        en = 1'b0;
        tick(2);
        sig_in = 1'b0;
        tick(4);
        check("queue_drained", q.size(), 0);
    endtask

    row_t rows[5];
    int   c0;

    initial begin
        rows[0] = '{h: 5,  l: 5,  n: 4, exp_p: 10, exp_h: 5};
        rows[1] = '{h: 3,  l: 7,  n: 4, exp_p: 10, exp_h: 3};
        rows[2] = '{h: 1,  l: 1,  n: 6, exp_p: 2,  exp_h: 1};
        rows[3] = '{h: 24, l: 25, n: 2, exp_p: 49, exp_h: 24};
        rows[4] = '{h: 1,  l: 2,  n: 3, exp_p: 3,  exp_h: 1};

        tick(3);
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_state", int'(dut.r_state), int'(IDLE));
        rst = 1'b0;
        tick(2);

        foreach (rows[r]) begin
            en = 1'b1;
            tick(3);
            check("row_armed", int'(dut.r_state), int'(ARM));
            drive(rows[r].h, rows[r].l, rows[r].n,
                  rows[r].exp_p, rows[r].exp_h);
            tick(6);
            check("row_busy_held", busy_ok, 1);
            en = 1'b0;
            tick(2);
            check("row_busy_off", busy, 0);
            sig_in = 1'b0;
            tick(4);
            check("queue_drained", q.size(), 0);
        end

        // Timeout: one rise then held high.
        en = 1'b1;
        tick(3);
        sig_in = 1'b1;
        tick(52);
        check("timeout_before_limit", timeout, 0);
        tick(1);
        check("timeout_set", timeout, 1);
        check("timeout_state_arm", int'(dut.r_state), int'(ARM));
        check("timeout_period_hold", period, 3);
        check("timeout_high_hold", high_time, 1);
        sig_in = 1'b0;
        tick(10);
        check("timeout_sticky", timeout, 1);
        drive(10, 10, 2, 20, 10);
        tick(4);
        check("timeout_cleared", timeout, 0);
        finish_run();

        // en drop while in LOW.
        en = 1'b1;
        tick(3);
        drive(6, 6, 1, 12, 6);
        tick(6);
        sig_in = 1'b0;
        tick(5);
        check("endrop_in_low", int'(dut.r_state), int'(LOW));
        en = 1'b0;
        tick(1);
        check("endrop_busy", busy, 0);
        check("endrop_timeout", timeout, 0);
        check("endrop_period_hold", period, 12);
        check("endrop_state", int'(dut.r_state), int'(IDLE));
        tick(3);
        check("endrop_no_pending", q.size(), 0);
        en = 1'b1;
        tick(3);
        check("reen_state_arm", int'(dut.r_state), int'(ARM));
        c0 = cyc;
        drive(4, 4, 1, 8, 4);
        tick(5);
        check("reen_first_valid_latency", last_vcyc - c0, 11);
        finish_run();

        // Reset in the middle of HIGH.
        en = 1'b1;
        tick(3);
        sig_in = 1'b1;
        tick(5);
        check("rstmid_busy_before", busy, 1);
        rst = 1'b1;
        sig_in = 1'b0;
        tick(1);
        check("rstmid_period", period, 0);
        check("rstmid_high_time", high_time, 0);
        check("rstmid_valid", valid, 0);
        check("rstmid_timeout", timeout, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_state", int'(dut.r_state), int'(IDLE));
        rst = 1'b0;
        tick(3);
        check("rstmid_rearmed", int'(dut.r_state), int'(ARM));
        drive(7, 7, 2, 14, 7);
        finish_run();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
